// File: rtl/ledsd_pkg.sv
// rtl/ledsd_pkg.sv - shared 7-segment code definitions and decoder
package ledsd_pkg;

    localparam logic [4:0] CODE_H     = 5'd16;
    localparam logic [4:0] CODE_L     = 5'd17;
    localparam logic [4:0] CODE_N     = 5'd18;
    localparam logic [4:0] CODE_O     = 5'd19;
    localparam logic [4:0] CODE_P     = 5'd20;
    localparam logic [4:0] CODE_Q     = 5'd21;
    localparam logic [4:0] CODE_U     = 5'd22;
    localparam logic [4:0] CODE_Y     = 5'd23;
    localparam logic [4:0] CODE_DASH  = 5'd24;
    localparam logic [4:0] CODE_EQ    = 5'd25;

    // Active-high pattern, bit 6 = g ... bit 0 = a; unknown codes are dark.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:      pat = 7'h3F;
            5'd1:      pat = 7'h06;
            5'd2:      pat = 7'h5B;
            5'd3:      pat = 7'h4F;
            5'd4:      pat = 7'h66;
            5'd5:      pat = 7'h6D;
            5'd6:      pat = 7'h7D;
            5'd7:      pat = 7'h07;
            5'd8:      pat = 7'h7F;
            5'd9:      pat = 7'h6F;
            5'd10:     pat = 7'h77;
            5'd11:     pat = 7'h7C;
            5'd12:     pat = 7'h39;
            5'd13:     pat = 7'h5E;
            5'd14:     pat = 7'h79;
            5'd15:     pat = 7'h71;
            CODE_H:    pat = 7'h76;
            CODE_L:    pat = 7'h38;
            CODE_N:    pat = 7'h54;
            CODE_O:    pat = 7'h5C;
            CODE_P:    pat = 7'h73;
            CODE_Q:    pat = 7'h67;
            CODE_U:    pat = 7'h3E;
            CODE_Y:    pat = 7'h6E;
            CODE_DASH: pat = 7'h40;
            CODE_EQ:   pat = 7'h48;
            default:   pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/ledsd_scan.sv
// rtl/ledsd_scan.sv - multiplexed 7-segment scanner with blanking, blink and PWM
module ledsd_scan
    import ledsd_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int COM       = 1,
    parameter int E_CODE    = 0,
    parameter int SCAN_DIV  = 1024,
    parameter int BRIGHT_W  = 3,
    parameter int BLINK_DIV = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM*(4+E_CODE)-1:0]   data_in,
    input  logic [NUM-1:0]              dp_in,
    input  logic [NUM-1:0]              dig_en,
    input  logic [NUM-1:0]              blink_en,
    input  logic                        blank_zero,
    input  logic [BRIGHT_W-1:0]         bright,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [NUM-1:0]              dig,
    output logic                        frame_tick
);

    localparam int   CW   = 4 + E_CODE;
    localparam int   PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int   SW   = $clog2(NUM);
    localparam int   FW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int   STEP = SCAN_DIV >> BRIGHT_W;
    localparam logic CP   = COM[0];

    logic [PW-1:0]       pre;
    logic [SW-1:0]       slot;
    logic [FW-1:0]       frame_cnt;
    logic                phase;
    logic                started;

    logic [CW-1:0]       snap_data [NUM];
    logic [NUM-1:0]      snap_dp;
    logic [NUM-1:0]      snap_en;
    logic [NUM-1:0]      snap_blink;
    logic                snap_bz;
    logic [BRIGHT_W-1:0] snap_bright;

    logic                pre_term;
    logic                slot_last;
    logic                snap_take;
    logic [PW:0]         on_len;
    logic [NUM-1:0]      lead_blank;
    logic                lit;
    logic [6:0]          cur_pat;

    assign pre_term  = (pre == PW'(SCAN_DIV - 1));
    assign slot_last = (slot == SW'(NUM - 1));
    // The very first cycle out of reset loads a snapshot so frame 0 is coherent.
    assign snap_take = !started || (pre_term && slot_last);
    assign on_len    = (PW+1)'((int'(snap_bright) + 1) * STEP);

    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        lead_blank = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            all_zero      = all_zero && (snap_data[i] == '0);
            lead_blank[i] = all_zero && snap_bz && (i != 0);
        end
    end

    assign lit = started && ({1'b0, pre} < on_len) && snap_en[slot] &&
                 !(phase && snap_blink[slot]);
    assign cur_pat = lead_blank[slot] ? 7'h00 : seg_decode(5'(snap_data[slot]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre         <= '0;
            slot        <= '0;
            frame_cnt   <= '0;
            phase       <= 1'b0;
            started     <= 1'b0;
            for (int i = 0; i < NUM; i++) snap_data[i] <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_blink  <= '0;
            snap_bz     <= 1'b0;
            snap_bright <= '0;
            seg         <= {7{CP}};
            dp          <= CP;
            dig         <= {NUM{CP}};
            frame_tick  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (started) begin
                pre <= pre_term ? '0 : pre + 1'b1;
                if (pre_term) slot <= slot_last ? '0 : slot + 1'b1;
            end

            frame_tick <= snap_take;
            if (snap_take) begin
                for (int i = 0; i < NUM; i++) snap_data[i] <= data_in[i*CW +: CW];
                snap_dp     <= dp_in;
                snap_en     <= dig_en;
                snap_blink  <= blink_en;
                snap_bz     <= blank_zero;
                snap_bright <= bright;
                // Frame 0 after reset is not counted; later snapshots advance blink.
                if (started) begin
                    if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                        frame_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end

            if (lit) begin
                seg <= {7{CP}} ^ cur_pat;
                dp  <= CP ^ snap_dp[slot];
                dig <= {NUM{CP}} ^ (NUM'(1) << slot);
            end else begin
                seg <= {7{CP}};
                dp  <= CP;
                dig <= {NUM{CP}};
            end
        end
    end

endmodule

// File: tb/tb_ledsd_scan.sv
// tb/tb_ledsd_scan.sv - self-checking bench for ledsd_scan
module tb_ledsd_scan;

    localparam int   NUM = 4;
    localparam int   CW  = 5;
    localparam int   SD  = 8;
    localparam int   BW  = 3;
    localparam int   BD  = 2;
    localparam logic COMV = 1'b0;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM*CW-1:0]   data_in;
    logic [NUM-1:0]      dp_in, dig_en, blink_en;
    logic                blank_zero;
    logic [BW-1:0]       bright;
    logic [6:0]          seg;
    logic                dp;
    logic [NUM-1:0]      dig;
    logic                frame_tick;

    int tests = 0;
    int fails = 0;

    int k = 0;
    int m_data [NUM];
    bit m_dp [NUM];
    bit m_en [NUM];
    bit m_bl [NUM];
    bit m_bz;
    int m_br;

    logic [6:0]     e_seg;
    logic           e_dp;
    logic [NUM-1:0] e_dig;
    logic           e_ft;

    ledsd_scan #(
        .NUM(NUM), .COM(0), .E_CODE(1), .SCAN_DIV(SD), .BRIGHT_W(BW), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .dig_en(dig_en), .blink_en(blink_en), .blank_zero(blank_zero),
        .bright(bright), .seg(seg), .dp(dp), .dig(dig), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input int c);
        case (c)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
            4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
            8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
           12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  15: return 7'h71;
           16: return 7'h76;  17: return 7'h38;  18: return 7'h54;  19: return 7'h5C;
           20: return 7'h73;  21: return 7'h67;  22: return 7'h3E;  23: return 7'h6E;
           24: return 7'h40;  25: return 7'h48;
            default: return 7'h00;
        endcase
    endfunction

    task automatic capture();
        for (int i = 0; i < NUM; i++) begin
            m_data[i] = int'(data_in[i*CW +: CW]);
            m_dp[i]   = dp_in[i];
            m_en[i]   = dig_en[i];
            m_bl[i]   = blink_en[i];
        end
        m_bz = blank_zero;
        m_br = int'(bright);
    endtask

    // One clock: derive expected pins from elapsed time since reset, then compare.
    task automatic step();
        int  n, pre, s, fr;
        bit  lead;
        @(posedge clk);
        e_seg = '0; e_dp = 1'b0; e_dig = '0; e_ft = 1'b0;
        if (!rst_n) begin
            k = 0;
        end else if (k == 0) begin
            e_ft = 1'b1;
            capture();
            k = 1;
        end else begin
            n   = k - 1;
            pre = n % SD;
            s   = (n / SD) % NUM;
            fr  = n / (SD * NUM);
            lead = m_bz && (s >= 1);
            for (int j = s; j < NUM; j++) if (m_data[j] != 0) lead = 1'b0;
            if (pre < (m_br + 1) * (SD >> BW) && m_en[s] && !(((fr / BD) % 2 == 1) && m_bl[s])) begin
                e_dig = NUM'(1) << s;
                e_seg = lead ? 7'h00 : hex_seg(m_data[s]);
                e_dp  = m_dp[s];
            end
            if (n % (SD * NUM) == SD * NUM - 1) begin
                e_ft = 1'b1;
                capture();
            end
            k++;
        end
        e_seg = e_seg ^ {7{COMV}};
        e_dp  = e_dp ^ COMV;
        e_dig = e_dig ^ {NUM{COMV}};
        #1;
        tests++;
        if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft}) begin
            fails++;
            $display("FAIL cycle k=%0d: got seg=%h dp=%b dig=%b ft=%b, want seg=%h dp=%b dig=%b ft=%b",
                     k, seg, dp, dig, frame_tick, e_seg, e_dp, e_dig, e_ft);
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ft();
        int i;
        for (i = 0; i < 80; i++) begin
            step();
            if (frame_tick) break;
        end
        check("wait_frame_tick", int'(i < 80), 1);
    endtask

    task automatic wait_dig(input logic [NUM-1:0] target);
        int i;
        for (i = 0; i < 80; i++) begin
            step();
            if (dig == target) break;
        end
        check("wait_dig", int'(i < 80), 1);
    endtask

    task automatic set_data(input int d3, input int d2, input int d1, input int d0);
        data_in = {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endtask

    initial begin
        int c0, c1, multi, bad, seen;
        set_data(3, 2, 1, 0);
        dp_in = '0; dig_en = '1; blink_en = '0; blank_zero = 1'b0; bright = 3'd7;
        rst_n = 1'b0;

        repeat (5) begin
            step();
            check("reset_dig", int'(dig), 0);
        end
        rst_n = 1'b1;
        step();
        check("first_tick", int'(frame_tick), 1);
        step();
        check("first_dig", int'(dig), 1);
        check("first_seg", int'(seg), 'h3F);
        repeat (62) step();

        set_data(0, 0, 0, 5);
        dp_in = 4'b0100; blank_zero = 1'b1;
        wait_ft();
        wait_dig(4'b0001); check("lz_dig0_seg", int'(seg), 'h6D);
        wait_dig(4'b0010); check("lz_dig1_seg", int'(seg), 0); check("lz_dig1_dp", int'(dp), 0);
        wait_dig(4'b0100); check("lz_dig2_seg", int'(seg), 0); check("lz_dig2_dp", int'(dp), 1);
        wait_dig(4'b1000); check("lz_dig3_seg", int'(seg), 0);

        set_data(3, 2, 1, 0);
        dp_in = '0; blank_zero = 1'b0; bright = 3'd0;
        wait_ft();
        c0 = 0; multi = 0;
        repeat (32) begin
            step();
            if (dig == 4'b0001) c0++;
            if ($countones(dig) > 1) multi++;
        end
        check("bright0_on", c0, 1);
        bright = 3'd3;
        wait_ft();
        c0 = 0;
        repeat (32) begin
            step();
            if (dig == 4'b0001) c0++;
            if ($countones(dig) > 1) multi++;
        end
        check("bright3_on", c0, 4);
        check("one_hot", multi, 0);

        bright = 3'd7; blink_en = 4'b0010;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        c0 = 0; c1 = 0;
        repeat (6 * 32) begin
            step();
            if (dig == 4'b0001) c0++;
            if (dig == 4'b0010) c1++;
        end
        check("blink_dig1_lit", c1, 32);
        check("blink_dig0_lit", c0, 48);

        blink_en = '0;
        set_data(3, 2, 1, 1);
        wait_ft();
        step(); step();
        set_data(3, 2, 1, 17);
        bad = 0; seen = 0;
        repeat (28) begin
            step();
            if (dig == 4'b0001) begin
                seen++;
                if (seg != 7'h06) bad++;
            end
        end
        check("snap_old_seen", seen, 6);
        check("snap_old_kept", bad, 0);
        wait_ft();
        wait_dig(4'b0001); check("ext_L_seg", int'(seg), 'h38);
        set_data(3, 2, 1, 30);
        wait_ft();
        wait_dig(4'b0001); check("ext_bad_seg", int'(seg), 0);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ledsd_scan.md
Name: ledsd_scan

Overview:
- Time-multiplexed 7-segment display driver: NUM digits share one segment/dp bus; one digit-select line per digit.
- Successor to the direct-drive hex display peripheral. Adds scanning, leading-zero blanking, per-digit blink and PWM brightness.
- Sits in the SOC peripheral set; data and control inputs come from a register block.

Parameters:
- NUM, 4, number of digits (2..16); digit NUM-1 is the most significant.
- COM, 1, common-terminal polarity; every output pin = COM XOR active-high logical value.
- E_CODE, 0, 1 enables 5-bit extended code (H L n o P q U y - =); 0 gives 4-bit hex.
- SCAN_DIV, 1024, clk cycles per digit slot; must be a multiple of 2**BRIGHT_W and >= 2**BRIGHT_W.
- BRIGHT_W, 3, brightness control width.
- BLINK_DIV, 64, full scan frames per blink half-period (>= 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- data_in  input  [3+E_CODE:0] x NUM  per-digit code
- dp_in  input  1 x NUM  per-digit decimal point
- dig_en  input  1 x NUM  digit enable; a disabled digit is dark but still consumes its slot
- blink_en  input  1 x NUM  per-digit blink enable
- blank_zero  input  1  leading-zero blanking enable
- bright  input  [BRIGHT_W-1:0]  duty level; 0 = 1/2**BRIGHT_W, max = full on
- seg  output  [6:0]  segments g..a
- dp  output  1  decimal point
- dig  output  [NUM-1:0]  digit selects, one-hot when active
- frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values:
  - prescaler = 0, slot = 0, frame counter = 0, blink phase = 0, snapshot cleared.
  - seg = {7{COM}}, dp = COM, dig = {NUM{COM}} (all dark), frame_tick = 0.
  - Reset asserted mid-frame aborts immediately; the next cycle shows all outputs dark.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, slot advances; NUM-1 wraps to 0.
- Snapshot:
  - data_in, dp_in, dig_en, blink_en, blank_zero and bright are sampled into the snapshot when slot wraps to 0, and on the first cycle after reset release.
  - A whole frame displays one coherent snapshot; input changes mid-frame take effect at the next frame.
- frame_tick: asserted for exactly the cycle in which the snapshot is taken.
- Blink:
  - Frame counter counts snapshots 0..BLINK_DIV-1; on wrap, blink phase toggles.
  - While phase = 1, digits with blink_en set are dark (segments, dp and select).
- Leading-zero blanking:
  - Digit i (i >= 1) is blanked when blank_zero = 1 and data for every digit j >= i is 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if dp_in is set; its select is driven.
- Decode:
  - Codes 0..15 give hex 0-F; 16..25 give H L n o P q U y - =.
  - Any other code (only possible with E_CODE = 1) gives all segments off.
- Brightness:
  - on_len = (bright+1)*(SCAN_DIV>>BRIGHT_W).
  - The current digit is active while prescaler < on_len; otherwise seg, dp and dig are all dark.
- Ghosting: at every slot boundary, dig changes in the same cycle as seg; no overlap of two selects is ever permitted.
- Outputs are registered: one cycle latency from prescaler/slot state to pins.

Decomposition:
- Package ledsd_pkg:
  - function seg_decode(5-bit code) -> 7-bit active-high pattern.
  - localparams for the extended code values.
  - Shared with the direct-drive peripheral.
- Sub-module: none required. Prescaler, slot, blink and PWM logic stay in ledsd_scan.

Test Plan:
Bench configuration: NUM=4, SCAN_DIV=8, BRIGHT_W=3, BLINK_DIV=2, COM=0, E_CODE=1.
- Reset: hold rst_n=0 for 5 cycles, then release -> seg=0, dp=0, dig=0 during reset; frame_tick pulses on the first cycle after release; dig=0001 one cycle later.
- Scan order and decode: data={3,2,1,0}, bright=7, all dig_en=1 -> dig cycles 0001,0010,0100,1000 with 8 cycles each; seg=3F,06,5B,4F; frame_tick every 32 cycles.
- Leading-zero blanking and dp: data={0,0,0,5}, dp_in[2]=1, blank_zero=1 -> digit0 seg=6D; digit1 and digit3 seg=00 with dp=0; digit2 seg=00 with dp=1.
- Brightness: bright=0 -> each digit active for 1 of 8 cycles. bright=3 -> active for 4 of 8 cycles. Never more than one dig bit set.
- Blink: blink_en[1]=1 -> digit1 dark in frames 2-3, lit in frames 0-1 and 4-5; other digits unaffected.
- Snapshot and extended code: change data[0] from 1 to 17 mid-frame -> the old value persists until the next frame_tick, then seg=38. Code 30 gives seg=00.
